touch_grid_select: RTL and testbench

- Parametrised touch-panel cell selector for the LCD menu screens; a generalised successor to the fixed 2x3 colour-choice picker.
- Maps raw 12-bit resistive touch coordinates onto a ROWS x COLS grid of rectangular cells.
- Debounces the press and emits a one-cycle selection pulse plus a held cell index.
- Supports one-shot and continuous re-arm modes. Cell-to-value mapping (e.g. colour codes) and pixel drawing live in the instantiating screen module.

---
 rtl/lcd_ui_pkg.sv | 29 ++
 rtl/touch_grid_select_if.sv | 30 +++
 rtl/touch_cell_hit.sv | 30 +++
 rtl/touch_grid_select.sv | 148 ++++++++++++++
 tb/tb_touch_grid_select.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_ui_pkg.sv
// Shared LCD menu definitions: selector FSM states, touch coordinate width and
// the default resistive-panel calibration used by the grid pickers.
package lcd_ui_pkg;

  localparam int TOUCH_W = 12;

  // Default calibration for the menu panel (lower corner of cell 0, pitch, size)
  localparam int CAL_X_ORIGIN = 1923;
  localparam int CAL_X_STEP   = 597;
  localparam int CAL_X_LEN    = 568;
  localparam int CAL_Y_ORIGIN = 1808;
  localparam int CAL_Y_STEP   = 823;
  localparam int CAL_Y_LEN    = 748;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_ARM          = 3'd1,
    ST_WAIT_PRESS   = 3'd2,
    ST_DEBOUNCE     = 3'd3,
    ST_WAIT_RELEASE = 3'd4,
    ST_DONE         = 3'd5
  } state_t;

  // A zero-length delay still needs one cycle of the counter.
  function automatic int at_least_one(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/touch_grid_select_if.sv
// Touch-in / selection-out bundle between a menu screen and its grid selector.
interface touch_grid_select_if #(
  parameter int IW = 3
);
  import lcd_ui_pkg::*;

  logic               active;
  logic [TOUCH_W-1:0] x_touch;
  logic [TOUCH_W-1:0] y_touch;
  logic               touch_input;
  logic               hover_valid;
  logic [IW-1:0]      hover_index;
  logic               sel_valid;
  logic [IW-1:0]      sel_index;
  logic               locked;
  state_t             dbg_state;

  // sel_valid is a one-cycle pulse with no back-pressure: the consumer must take
  // sel_index in that cycle (it also holds until the next acceptance or IDLE).
  modport master (
    output active, x_touch, y_touch, touch_input,
    input  hover_valid, hover_index, sel_valid, sel_index, locked, dbg_state
  );

  modport slave (
    input  active, x_touch, y_touch, touch_input,
    output hover_valid, hover_index, sel_valid, sel_index, locked, dbg_state
  );

endinterface

// File: rtl/touch_cell_hit.sv
// Single-rectangle hit comparator: corner <= coord < corner+len on both axes,
// evaluated with one spare bit so corner+len may reach 4096.
module touch_cell_hit
  import lcd_ui_pkg::*;
#(
  parameter int CORNER_X = 0,
  parameter int LEN_X    = 1,
  parameter int CORNER_Y = 0,
  parameter int LEN_Y    = 1
) (
  input  logic               en,
  input  logic [TOUCH_W-1:0] x,
  input  logic [TOUCH_W-1:0] y,
  output logic               hit
);

  localparam int CW = TOUCH_W + 1;
  localparam logic [CW-1:0] X_LO = CW'(CORNER_X);
  localparam logic [CW-1:0] X_HI = CW'(CORNER_X + LEN_X);
  localparam logic [CW-1:0] Y_LO = CW'(CORNER_Y);
  localparam logic [CW-1:0] Y_HI = CW'(CORNER_Y + LEN_Y);

  logic [CW-1:0] xe;
  logic [CW-1:0] ye;

  assign xe  = {1'b0, x};
  assign ye  = {1'b0, y};
  assign hit = en & (xe >= X_LO) & (xe < X_HI) & (ye >= Y_LO) & (ye < Y_HI);

endmodule

// File: rtl/touch_grid_select.sv
// ROWS x COLS touch-cell selector: per-cell hit test, one-hot encoder, and an
// arm/debounce FSM producing a one-cycle selection pulse and a held index.
module touch_grid_select
  import lcd_ui_pkg::*;
#(
  parameter int ROWS       = 2,
  parameter int COLS       = 3,
  parameter int X_ORIGIN   = CAL_X_ORIGIN,
  parameter int X_STEP     = CAL_X_STEP,
  parameter int X_LEN      = CAL_X_LEN,
  parameter int Y_ORIGIN   = CAL_Y_ORIGIN,
  parameter int Y_STEP     = CAL_Y_STEP,
  parameter int Y_LEN      = CAL_Y_LEN,
  parameter int ARM_DELAY  = 15000,
  parameter int DEBOUNCE   = 3000,
  parameter int CONTINUOUS = 0
) (
  input logic               clk,
  input logic               rst,
  touch_grid_select_if.slave bus
);

  localparam int NCELL   = ROWS * COLS;
  localparam int IW      = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam int ARM_CYC = at_least_one(ARM_DELAY);
  localparam int DEB_CYC = at_least_one(DEBOUNCE);
  localparam int CNT_MAX = (ARM_CYC > DEB_CYC) ? ARM_CYC : DEB_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] ARM_LOAD = CW'(ARM_CYC - 1);
  localparam logic [CW-1:0] DEB_LOAD = CW'(DEB_CYC - 1);

  logic [NCELL-1:0] cell_hit;
  logic             touch_en;
  logic             found;
  logic             multi;
  logic             hit;
  logic [IW-1:0]    hit_idx;

  assign touch_en = bus.touch_input & bus.active;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int CX = X_ORIGIN - c * X_STEP;
      localparam int CY = Y_ORIGIN - r * Y_STEP;
      if (CX < 0 || CX + X_LEN > 4096 || CY < 0 || CY + Y_LEN > 4096) begin : g_bad
        $error("touch_grid_select: cell (%0d,%0d) lies outside the touch range", r, c);
      end
      touch_cell_hit #(
        .CORNER_X(CX), .LEN_X(X_LEN), .CORNER_Y(CY), .LEN_Y(Y_LEN)
      ) u_hit (
        .en (touch_en),
        .x  (bus.x_touch),
        .y  (bus.y_touch),
        .hit(cell_hit[r*COLS+c])
      );
    end
  end

  // Overlapping calibrations can light two cells; that is treated as no hit.
  always_comb begin
    found   = 1'b0;
    multi   = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < NCELL; i++) begin
      if (cell_hit[i]) begin
        multi   = multi | found;
        found   = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  assign hit = found & ~multi;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] cand;

  assign bus.dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      cand            <= '0;
      bus.hover_valid <= 1'b0;
      bus.hover_index <= '0;
      bus.sel_valid   <= 1'b0;
      bus.sel_index   <= '0;
      bus.locked      <= 1'b0;
    end else begin
      bus.hover_valid <= hit;
      if (hit) bus.hover_index <= hit_idx;
      bus.sel_valid <= 1'b0;
      // Losing the screen beats everything, including a completing debounce.
      if (!bus.active && state != ST_IDLE) begin
        state         <= ST_IDLE;
        cnt           <= '0;
        bus.sel_index <= '0;
        bus.locked    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            bus.sel_index <= '0;
            if (bus.active) begin
              cnt   <= ARM_LOAD;
              state <= ST_ARM;
            end
          end
          ST_ARM: begin
            if (cnt == '0) state <= ST_WAIT_PRESS;
            else           cnt   <= cnt - 1'b1;
          end
          ST_WAIT_PRESS: begin
            if (hit) begin
              cand  <= hit_idx;
              cnt   <= DEB_LOAD;
              state <= ST_DEBOUNCE;
            end
          end
          ST_DEBOUNCE: begin
            if (!hit || hit_idx != cand) begin
              cnt   <= '0;
              state <= ST_WAIT_PRESS;
            end else if (cnt == '0) begin
              bus.sel_valid <= 1'b1;
              bus.sel_index <= cand;
              if (CONTINUOUS == 0) begin
                bus.locked <= 1'b1;
                state      <= ST_DONE;
              end else begin
                state <= ST_WAIT_RELEASE;
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          ST_WAIT_RELEASE: begin
            if (!bus.touch_input) state <= ST_WAIT_PRESS;
          end
          ST_DONE:  bus.locked <= 1'b1;
          default:  state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_touch_grid_select.sv
// Directed bench for touch_grid_select (ARM_DELAY=4, DEBOUNCE=3, default grid):
// a one-shot instance and a continuous instance share the same touch stimulus.
module tb_touch_grid_select;
  import lcd_ui_pkg::*;

  localparam int IW = 3;
  localparam int O_HV = 0, O_HI = 1, O_SV = 2, O_SI = 3, O_LK = 4, O_ST = 5;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        active;
  logic        touch;
  logic [11:0] tx;
  logic [11:0] ty;
  bit          sel_b;
  int          vectors = 0;
  int          errors  = 0;
  int          pulses;

  touch_grid_select_if #(.IW(IW)) bif_a ();
  touch_grid_select_if #(.IW(IW)) bif_b ();

  assign bif_a.active      = active;
  assign bif_a.x_touch     = tx;
  assign bif_a.y_touch     = ty;
  assign bif_a.touch_input = touch;
  assign bif_b.active      = active;
  assign bif_b.x_touch     = tx;
  assign bif_b.y_touch     = ty;
  assign bif_b.touch_input = touch;

  touch_grid_select #(.ARM_DELAY(4), .DEBOUNCE(3), .CONTINUOUS(0)) dut_a (
    .clk(clk), .rst(rst), .bus(bif_a)
  );
  touch_grid_select #(.ARM_DELAY(4), .DEBOUNCE(3), .CONTINUOUS(1)) dut_b (
    .clk(clk), .rst(rst), .bus(bif_b)
  );

  function automatic logic [31:0] obs(input int what);
    logic [31:0] v;
    v = '0;
    case (what)
      O_HV: v = 32'(sel_b ? bif_b.hover_valid : bif_a.hover_valid);
      O_HI: v = 32'(sel_b ? bif_b.hover_index : bif_a.hover_index);
      O_SV: v = 32'(sel_b ? bif_b.sel_valid   : bif_a.sel_valid);
      O_SI: v = 32'(sel_b ? bif_b.sel_index   : bif_a.sel_index);
      O_LK: v = 32'(sel_b ? bif_b.locked      : bif_a.locked);
      O_ST: v = 32'(sel_b ? bif_b.dbg_state   : bif_a.dbg_state);
      default: v = '0;
    endcase
    return v;
  endfunction

  // Driver tasks
  task automatic chk(input string tag, input int what, input logic [31:0] exp);
    logic [31:0] o;
    o = obs(what);
    vectors++;
    assert (o === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, o, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic touch_at(input int x, input int y);
    tx    = 12'(x);
    ty    = 12'(y);
    touch = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_hv"}, O_HV, 0);
    chk({tag, "_hi"}, O_HI, 0);
    chk({tag, "_sv"}, O_SV, 0);
    chk({tag, "_si"}, O_SI, 0);
    chk({tag, "_lk"}, O_LK, 0);
    chk({tag, "_st"}, O_ST, 32'(ST_IDLE));
  endtask

  // From IDLE with active just raised: 4 cycles in ARM, then WAIT_PRESS.
  task automatic arm_to_wait_press(input string tag, input logic exp_hv, input int exp_hi);
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 0) begin
        chk({tag, "_hover_valid"}, O_HV, 32'(exp_hv));
        chk({tag, "_hover_index"}, O_HI, 32'(exp_hi));
      end
      chk({tag, "_arm_state"}, O_ST, 32'(ST_ARM));
      chk({tag, "_arm_nosel"}, O_SV, 0);
    end
    step();
    chk({tag, "_wait_press"}, O_ST, 32'(ST_WAIT_PRESS));
  endtask

  // From WAIT_PRESS with a stable touch: 3 cycles in DEBOUNCE, pulse on the next.
  task automatic debounce_expect(input string tag, input int idx, input state_t after);
    for (int i = 0; i < 3; i++) begin
      step();
      chk({tag, "_deb_state"}, O_ST, 32'(ST_DEBOUNCE));
      chk({tag, "_deb_nosel"}, O_SV, 0);
    end
    step();
    chk({tag, "_sel_valid"}, O_SV, 1);
    chk({tag, "_sel_index"}, O_SI, 32'(idx));
    chk({tag, "_locked"},    O_LK, (after == ST_DONE) ? 1 : 0);
    chk({tag, "_after"},     O_ST, 32'(after));
    step();
    chk({tag, "_one_cycle"}, O_SV, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; active = 1'b0; touch = 1'b0; tx = '0; ty = '0; sel_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sel_b = 1'b0; check_zero("reset_a");
    sel_b = 1'b1; check_zero("reset_b");
    sel_b = 1'b0;
    @(negedge clk) rst = 1'b0;

    // One-shot: touch held from activation, ignored during ARM.
    touch_at(2000, 1900); active = 1'b1;
    arm_to_wait_press("s1", 1'b1, 0);
    debounce_expect("s1", 0, ST_DONE);
    repeat (5) step();
    chk("s1_done_state", O_ST, 32'(ST_DONE));
    chk("s1_done_lock",  O_LK, 1);
    chk("s1_done_nosel", O_SV, 0);

    // Hover boundaries while locked (hover keeps tracking).
    touch_at(1500, 1200); step(); chk("b_1500_1200_hv", O_HV, 1); chk("b_1500_1200_hi", O_HI, 4);
    touch_at(1893, 1900); step(); chk("b_1893_hv", O_HV, 1); chk("b_1893_hi", O_HI, 1);
    touch_at(1894, 1900); step(); chk("b_1894_hv", O_HV, 0); chk("b_1894_hold", O_HI, 1);
    touch_at(1922, 1808); step(); chk("b_1922_hv", O_HV, 0);
    touch_at(1923, 1807); step(); chk("b_y1807_hv", O_HV, 0);
    touch_at(1923, 1808); step(); chk("b_corner0_hv", O_HV, 1); chk("b_corner0_hi", O_HI, 0);
    touch = 1'b0; step(); chk("b_release_hv", O_HV, 0); chk("b_release_hold", O_HI, 0);
    chk("b_still_done", O_ST, 32'(ST_DONE));

    // Drop active, then select cells 4 and 5.
    active = 1'b0; step();
    chk("s2_idle", O_ST, 32'(ST_IDLE)); chk("s2_unlock", O_LK, 0);
    touch_at(1500, 1200); active = 1'b1;
    arm_to_wait_press("s2", 1'b1, 4);
    debounce_expect("s2", 4, ST_DONE);
    active = 1'b0; step();
    chk("s2_idle_si", O_SI, 0);
    touch_at(800, 1000); active = 1'b1;
    arm_to_wait_press("s2b", 1'b1, 5);
    debounce_expect("s2b", 5, ST_DONE);
    active = 1'b0; step();

    // Finger slides to a neighbour mid-debounce: restart, then accept cell 1.
    touch_at(2000, 1900); active = 1'b1;
    arm_to_wait_press("s3", 1'b1, 0);
    step(); chk("s3_deb1", O_ST, 32'(ST_DEBOUNCE));
    step(); chk("s3_deb2", O_ST, 32'(ST_DEBOUNCE));
    touch_at(1500, 1900); step();
    chk("s3_restart", O_ST, 32'(ST_WAIT_PRESS)); chk("s3_nosel", O_SV, 0);
    chk("s3_hover_hi", O_HI, 1);
    debounce_expect("s3", 1, ST_DONE);
    active = 1'b0; step();

    // Touch in the gap between columns never selects.
    touch_at(1910, 1900); active = 1'b1;
    arm_to_wait_press("s4", 1'b0, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("s4_gap_state", O_ST, 32'(ST_WAIT_PRESS));
      chk("s4_gap_nosel", O_SV, 0);
      chk("s4_gap_hv", O_HV, 0);
    end
    active = 1'b0; touch = 1'b0; step();

    // Continuous instance: held finger gives a single pulse, release re-arms.
    sel_b = 1'b1;
    touch_at(2000, 1900); active = 1'b1;
    arm_to_wait_press("c1", 1'b1, 0);
    debounce_expect("c1", 0, ST_WAIT_RELEASE);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (obs(O_SV) == 1) pulses++;
    end
    vectors++;
    assert (pulses == 0) else begin
      errors++;
      $error("FAIL c1_held_repeat: observed %0d extra pulses, expected 0", pulses);
    end
    chk("c1_held_state", O_ST, 32'(ST_WAIT_RELEASE));
    touch = 1'b0; step();
    chk("c1_released", O_ST, 32'(ST_WAIT_PRESS));
    touch_at(2000, 1900);
    debounce_expect("c1b", 0, ST_WAIT_RELEASE);
    touch = 1'b0; step();
    touch_at(800, 1000);
    debounce_expect("c2", 5, ST_WAIT_RELEASE);

    // Asynchronous reset in the middle of a debounce.
    touch = 1'b0; step();
    touch_at(1500, 1200); step(); step();
    chk("c3_pre_state", O_ST, 32'(ST_DEBOUNCE));
    chk("c3_pre_si", O_SI, 5);
    chk("c3_pre_hv", O_HV, 1);
    rst = 1'b1; #1;
    check_zero("c3_rst");
    active = 1'b0; touch = 1'b0;
    step(); step();
    @(negedge clk) rst = 1'b0;

    // active falls on the last debounce cycle: no pulse, index cleared.
    touch_at(800, 1000); active = 1'b1;
    arm_to_wait_press("c4", 1'b1, 5);
    debounce_expect("c4", 5, ST_WAIT_RELEASE);
    touch = 1'b0; step();
    touch_at(1500, 1200);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("c4_deb_state", O_ST, 32'(ST_DEBOUNCE));
    end
    active = 1'b0; step();
    chk("c4_drop_nosel", O_SV, 0);
    chk("c4_drop_state", O_ST, 32'(ST_IDLE));
    chk("c4_drop_si",    O_SI, 0);
    step();
    chk("c4_no_late_sel", O_SV, 0);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
